// File: rtl/seq_pattern_det.sv
// rtl/seq_pattern_det.sv - programmable serial pattern detector with match counter.
// Build option: SEQ_DET_CNT_SAT_EN makes match_cnt saturate instead of wrapping.
module seq_pattern_det #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    localparam int FW   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic             din,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    input  logic             clear,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic [FW-1:0]    fill
);

    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    localparam logic [FW-1:0] NEAR = FW'(PAT_W - 1);

    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-2:0] r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_shift;
    logic             w_beat;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_next;

    // Control events take the beat, so a beat coinciding with clear/pat_load is dropped.
    assign w_shift = {r_hist, din};
    assign w_beat  = din_vld && !clear && !pat_load;
    assign w_hit   = w_beat && (r_fill >= NEAR) && (w_shift == r_pat);

`ifdef SEQ_DET_CNT_SAT_EN
    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
`else
    assign w_cnt_next = r_cnt + CNT_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_match <= 1'b0;
            if (clear || pat_load) begin
                r_hist <= '0;
                r_fill <= '0;
                if (pat_load) r_pat <= pat_in;
                if (clear)    r_cnt <= '0;
            end else if (w_beat) begin
                if (w_hit) begin
                    r_match <= 1'b1;
                    r_cnt   <= w_cnt_next;
                    // Overlap keeps the window full so its tail can start the next match.
                    if (overlap_en) begin
                        r_hist <= w_shift[PAT_W-2:0];
                        r_fill <= FULL;
                    end else begin
                        r_hist <= '0;
                        r_fill <= '0;
                    end
                end else begin
                    r_hist <= w_shift[PAT_W-2:0];
                    r_fill <= (r_fill == FULL) ? FULL : r_fill + FW'(1);
                end
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign fill      = r_fill;

endmodule

// File: tb/tb_seq_pattern_det.sv
// tb/tb_seq_pattern_det.sv - directed vector bench for seq_pattern_det.
module tb_seq_pattern_det;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din_vld = 1'b0;
    logic       din = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'd0;
    logic       overlap_en = 1'b1;
    logic       clear = 1'b0;
    logic       match, match2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic [2:0] fill, fill2;

    int total = 0;
    int bad = 0;
    int pulses;
    int pulses2;

    typedef struct {
        logic       vld;
        logic       d;
        logic       clr;
        logic       ld;
        logic       ov;
        logic [3:0] pat;
        logic       e_match;
        logic [7:0] e_cnt;
        logic [2:0] e_fill;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_pattern_det #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .pat_load(pat_load),
        .pat_in(pat_in), .overlap_en(overlap_en), .clear(clear),
        .match(match), .match_cnt(match_cnt), .fill(fill)
    );

    seq_pattern_det #(.PAT_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .pat_load(pat_load),
        .pat_in(pat_in), .overlap_en(overlap_en), .clear(clear),
        .match(match2), .match_cnt(match_cnt2), .fill(fill2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic vld, input logic d, input logic clr, input logic ld,
                        input logic ov, input logic [3:0] pat);
        din_vld = vld; din = d; clear = clr; pat_load = ld; overlap_en = ov; pat_in = pat;
        @(posedge clk);
        #1;
        din_vld = 1'b0; clear = 1'b0; pat_load = 1'b0;
    endtask

    function automatic void add(input logic vld, input logic d, input logic clr, input logic ld,
                                input logic ov, input logic [3:0] pat,
                                input logic em, input logic [7:0] ec, input logic [2:0] ef);
        vec_t v;
        v.vld = vld; v.d = d; v.clr = clr; v.ld = ld; v.ov = ov; v.pat = pat;
        v.e_match = em; v.e_cnt = ec; v.e_fill = ef;
        vecs.push_back(v);
    endfunction

    initial begin
        // basic match 1011
        add(0,0,0,1,1,4'b1011, 0,0,0);
        add(1,1,0,0,1,4'b0000, 0,0,1);
        add(1,0,0,0,1,4'b0000, 0,0,2);
        add(1,1,0,0,1,4'b0000, 0,0,3);
        add(1,1,0,0,1,4'b0000, 1,1,4);
        add(0,0,0,0,1,4'b0000, 0,1,4);
        // overlapping 1010
        add(0,0,0,1,1,4'b1010, 0,1,0);
        add(0,0,1,0,1,4'b0000, 0,0,0);
        add(1,1,0,0,1,4'b0000, 0,0,1);
        add(1,0,0,0,1,4'b0000, 0,0,2);
        add(1,1,0,0,1,4'b0000, 0,0,3);
        add(1,0,0,0,1,4'b0000, 1,1,4);
        add(1,1,0,0,1,4'b0000, 0,1,4);
        add(1,0,0,0,1,4'b0000, 1,2,4);
        // non-overlapping 1010
        add(0,0,1,0,0,4'b0000, 0,0,0);
        add(1,1,0,0,0,4'b0000, 0,0,1);
        add(1,0,0,0,0,4'b0000, 0,0,2);
        add(1,1,0,0,0,4'b0000, 0,0,3);
        add(1,0,0,0,0,4'b0000, 1,1,0);
        add(1,1,0,0,0,4'b0000, 0,1,1);
        add(1,0,0,0,0,4'b0000, 0,1,2);
        // clear+load together, then clear mid-sequence with a beat
        add(0,0,1,1,1,4'b1011, 0,0,0);
        add(1,1,0,0,1,4'b0000, 0,0,1);
        add(1,0,0,0,1,4'b0000, 0,0,2);
        add(1,1,0,0,1,4'b0000, 0,0,3);
        add(1,1,1,0,1,4'b0000, 0,0,0);
        add(1,1,0,0,1,4'b0000, 0,0,1);
        // pat_load with a beat discards the beat
        add(1,0,0,1,1,4'b1011, 0,0,0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset_match", match, 0);
        check("reset_cnt", match_cnt, 0);
        check("reset_fill", fill, 0);
        check("reset_cnt2", match_cnt2, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].vld, vecs[i].d, vecs[i].clr, vecs[i].ld, vecs[i].ov, vecs[i].pat);
            check($sformatf("vec%0d_match", i), match, vecs[i].e_match);
            check($sformatf("vec%0d_cnt", i), match_cnt, vecs[i].e_cnt);
            check($sformatf("vec%0d_fill", i), fill, vecs[i].e_fill);
        end

        // gaps between bits with din toggling while idle
        begin
            logic [3:0] bits;
            bits = 4'b1011;
            pulses = 0;
            for (int b = 3; b >= 0; b--) begin
                step(1, bits[b], 0, 0, 1, 4'b0000);
                check($sformatf("gap_bit%0d", b), match, (b == 0) ? 1 : 0);
                pulses += match;
                for (int g = 0; g < 2; g++) begin
                    step(0, g[0] ^ bits[b], 0, 0, 1, 4'b0000);
                    check("gap_idle_match", match, 0);
                    pulses += match;
                end
            end
            check("gap_pulses", pulses, 1);
            check("gap_cnt", match_cnt, 1);
        end

        // counter limit on the 2-bit instance: 1011 then 011 x4 overlapping
        step(0, 0, 1, 1, 1, 4'b1011);
        check("lim_cnt2_cleared", match_cnt2, 0);
        begin
            logic [15:0] seq;
            seq = 16'b1011011011011011;
            pulses = 0;
            pulses2 = 0;
            for (int b = 15; b >= 0; b--) begin
                step(1, seq[b], 0, 0, 1, 4'b0000);
                pulses += match;
                pulses2 += match2;
            end
            step(0, 0, 0, 0, 1, 4'b0000);
            check("lim_pulses", pulses, 5);
            check("lim_pulses2", pulses2, 5);
            check("lim_cnt", match_cnt, 5);
`ifdef SEQ_DET_CNT_SAT_EN
            check("lim_cnt2", match_cnt2, 3);
`else
            check("lim_cnt2", match_cnt2, 1);
`endif
        end

        // reset mid-stream returns the pattern register to 0
        step(1, 1, 0, 0, 1, 4'b0000);
        rst = 1'b1;
        #2;
        check("rst_async_fill", fill, 0);
        check("rst_async_cnt", match_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int b = 0; b < 4; b++) begin
            step(1, 0, 0, 0, 1, 4'b0000);
            check($sformatf("rst_zero_pat%0d", b), match, (b == 3) ? 1 : 0);
        end
        check("rst_zero_cnt", match_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
